// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue controller.
// Contents:
//   - ALU select codes (SEL_*). Bit 3 is always 0.
//   - MIPS opcode (OP_*) and funct (FN_*) values for the supported subset.
//   - FSM state enum (state_t).
//   - Operation class enum (op_class_t). It selects how a captured ALU result is post-processed.
//   - sext16/zext16 immediate helpers.
package alu_issue_pkg;

  localparam logic [3:0] SEL_AND = 4'd0;
  localparam logic [3:0] SEL_OR  = 4'd1;
  localparam logic [3:0] SEL_ADD = 4'd2;
  localparam logic [3:0] SEL_XOR = 4'd3;
  localparam logic [3:0] SEL_SUB = 4'd4;
  localparam logic [3:0] SEL_SRA = 4'd5;
  localparam logic [3:0] SEL_SLL = 4'd6;
  localparam logic [3:0] SEL_NOR = 4'd7;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;

  typedef enum logic [2:0] {
    CLS_PLAIN, CLS_SLT, CLS_SLTU, CLS_BEQ, CLS_BNE, CLS_TRAP_ADD
  } op_class_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] zext16(input logic [15:0] v);
    return {16'h0000, v};
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational decoder. It maps opcode/funct/shamt/imm and the register values
// to ALU operands, an ALU select code and an operation class.
// Ports:
//   Inputs:  opcode, funct, shamt, imm, rs_val, rt_val
//   Outputs: a, b, s (ALU operands and select)
//            cls     (post-processing class)
//            illegal (encoding is not supported)
module alu_issue_decode
  import alu_issue_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  s,
  output op_class_t   cls,
  output logic        illegal
);

  always_comb begin
    a       = rs_val;
    b       = rt_val;
    s       = SEL_AND;
    cls     = CLS_PLAIN;
    illegal = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADD:  begin s = SEL_ADD; cls = CLS_TRAP_ADD; end
        FN_ADDU: s = SEL_ADD;
        FN_SUB:  begin s = SEL_SUB; cls = CLS_TRAP_ADD; end
        FN_SUBU: s = SEL_SUB;
        FN_AND:  s = SEL_AND;
        FN_OR:   s = SEL_OR;
        FN_XOR:  s = SEL_XOR;
        FN_NOR:  s = SEL_NOR;
        // Shifts take the shifted value from rt. The amount comes from shamt or rs.
        FN_SLL:  begin a = rt_val; b = {27'd0, shamt}; s = SEL_SLL; end
        FN_SRA:  begin a = rt_val; b = {27'd0, shamt}; s = SEL_SRA; end
        FN_SLLV: begin a = rt_val; b = rs_val;         s = SEL_SLL; end
        FN_SRAV: begin a = rt_val; b = rs_val;         s = SEL_SRA; end
        FN_SLT:  begin s = SEL_SUB; cls = CLS_SLT;  end
        FN_SLTU: begin s = SEL_SUB; cls = CLS_SLTU; end
        default: illegal = 1'b1;
      endcase
    end else begin
      case (opcode)
        OP_ADDI:  begin b = sext16(imm); s = SEL_ADD; cls = CLS_TRAP_ADD; end
        OP_ADDIU: begin b = sext16(imm); s = SEL_ADD; end
        OP_ANDI:  begin b = zext16(imm); s = SEL_AND; end
        OP_ORI:   begin b = zext16(imm); s = SEL_OR;  end
        OP_XORI:  begin b = zext16(imm); s = SEL_XOR; end
        OP_SLTI:  begin b = sext16(imm); s = SEL_SUB; cls = CLS_SLT;  end
        OP_SLTIU: begin b = sext16(imm); s = SEL_SUB; cls = CLS_SLTU; end
        OP_BEQ:   begin s = SEL_SUB; cls = CLS_BEQ; end
        OP_BNE:   begin s = SEL_SUB; cls = CLS_BNE; end
        OP_LUI:   begin a = zext16(imm); b = 32'd16; s = SEL_SLL; end
        default:  illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Sequential front end for the 32-bit combinational ALU.
// Operation:
//   - Accepts one decoded instruction.
//   - Drives registered operands and select to the ALU.
//   - Waits ALU_LAT cycles, then captures the result and flags.
//   - Returns the result with slt/sltu/branch/trap post-processing.
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready instruction handshake
//                     (in_opcode, in_funct, in_shamt, in_imm, in_rs_val, in_rt_val)
//   alu_A/B/S         registered ALU operands and select
//   alu_R, alu_zero, alu_overflow, alu_carry
//                     ALU result and flags
//   out_valid/out_ready result handshake
//                     (out_result, out_zero, out_ovf_trap, out_branch_taken, out_illegal)
// Handshakes: a transfer occurs on a rising edge where valid and ready are both high.
//   - in_ready is high only in IDLE.
//   - out_valid is high only in DONE.
//   - While out_valid is high, all out_* and alu_* stay constant until the transfer edge.
module alu_issue_ctrl
  import alu_issue_pkg::*;
#(
  parameter int unsigned ALU_LAT             = 1,
  parameter bit          SUB_CARRY_IS_BORROW = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_opcode,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [15:0] in_imm,
  input  logic [31:0] in_rs_val,
  input  logic [31:0] in_rt_val,
  output logic [31:0] alu_A,
  output logic [31:0] alu_B,
  output logic [3:0]  alu_S,
  input  logic [31:0] alu_R,
  input  logic        alu_zero,
  input  logic        alu_overflow,
  input  logic        alu_carry,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_zero,
  output logic        out_ovf_trap,
  output logic        out_branch_taken,
  output logic        out_illegal
);

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_t      state;
  op_class_t   cls_q;
  logic [2:0]  cnt;

  logic [31:0] dec_a, dec_b;
  logic [3:0]  dec_s;
  op_class_t   dec_cls;
  logic        dec_illegal;

  // The ALU zero flag only covers what the ALU computed. The zero flag reported here
  // is recomputed from the final post-processed result.
  logic        alu_zero_unused;
  assign alu_zero_unused = alu_zero;

  alu_issue_decode u_decode (
    .opcode  (in_opcode),
    .funct   (in_funct),
    .shamt   (in_shamt),
    .imm     (in_imm),
    .rs_val  (in_rs_val),
    .rt_val  (in_rt_val),
    .a       (dec_a),
    .b       (dec_b),
    .s       (dec_s),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  logic [31:0] cap_result;
  logic        cap_trap, cap_br, sltu_lt;

  // The meaning of the subtract carry depends on how the ALU was built:
  // it reports either "no borrow" (A>=B) or "borrow" (A<B).
  assign sltu_lt = SUB_CARRY_IS_BORROW ? alu_carry : ~alu_carry;

  always_comb begin
    cap_result = alu_R;
    cap_br     = 1'b0;
    case (cls_q)
      // Signed less-than is the sign of A-B, corrected when the subtraction overflowed.
      CLS_SLT:  cap_result = {31'd0, alu_R[31] ^ alu_overflow};
      CLS_SLTU: cap_result = {31'd0, sltu_lt};
      CLS_BEQ:  cap_br     = (alu_R == 32'd0);
      CLS_BNE:  cap_br     = (alu_R != 32'd0);
      default:  ;
    endcase
    cap_trap = (cls_q == CLS_TRAP_ADD) & alu_overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cls_q            <= CLS_PLAIN;
      cnt              <= 3'd0;
      in_ready         <= 1'b1;
      out_valid        <= 1'b0;
      alu_A            <= 32'd0;
      alu_B            <= 32'd0;
      alu_S            <= 4'd0;
      out_result       <= 32'd0;
      out_zero         <= 1'b0;
      out_ovf_trap     <= 1'b0;
      out_branch_taken <= 1'b0;
      out_illegal      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (dec_illegal) begin
              // There is nothing to execute. Report the illegal encoding immediately
              // and leave the ALU inputs unchanged.
              state            <= ST_DONE;
              out_valid        <= 1'b1;
              out_illegal      <= 1'b1;
              out_result       <= 32'd0;
              out_zero         <= 1'b1;
              out_ovf_trap     <= 1'b0;
              out_branch_taken <= 1'b0;
            end else begin
              state <= ST_EXEC;
              alu_A <= dec_a;
              alu_B <= dec_b;
              alu_S <= dec_s;
              cls_q <= dec_cls;
              cnt   <= LAT_INIT;
            end
          end
        end
        ST_EXEC: begin
          if (cnt <= 3'd1) begin
            state            <= ST_DONE;
            out_valid        <= 1'b1;
            out_illegal      <= 1'b0;
            out_result       <= cap_result;
            out_zero         <= ~|cap_result;
            out_ovf_trap     <= cap_trap;
            out_branch_taken <= cap_br;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
